flow_framer: RTL

Transmit-side frame generator for the per-frame statistics blocks in the flow datapath. It buffers a sample stream from upstream, then emits fixed-length, gap-free frames on a `dout`/`dout_tvalid`/`dout_tlast` interface. That interface carries no ready, so every frame must be delivered contiguously. Each frame is released only once all of its samples are already buffered.

---
 rtl/flow_pkg.sv | 12 +
 rtl/flow_fifo.sv | 63 ++++++
 rtl/flow_framer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/flow_pkg.sv
// Shared types and defaults for the flow datapath framing blocks.
package flow_pkg;

   localparam int unsigned DEFAULT_DATAWIDTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      GAP
   } framer_state_t;

endpackage

// File: rtl/flow_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags.
module flow_fifo
   import flow_pkg::*;
#(
   parameter int unsigned DATAWIDTH = DEFAULT_DATAWIDTH,
   parameter int unsigned DEPTH     = 256,
   localparam int unsigned AW       = $clog2(DEPTH),
   localparam int unsigned CW       = AW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_wr_en,
   input  logic [DATAWIDTH-1:0] i_wr_data,
   input  logic                 i_rd_en,
   output logic [DATAWIDTH-1:0] o_rd_data,
   output logic [CW-1:0]        o_count,
   output logic                 o_full,
   output logic                 o_empty
);

   logic [DATAWIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 w_wr;
   logic                 w_rd;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   // Full is judged on the registered count, so a same-cycle read never admits a write.
   assign w_wr = i_wr_en & ~o_full;
   assign w_rd = i_rd_en & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/flow_framer.sv
// Buffers an upstream sample stream and emits fixed-length, gap-free frames
// with a forced idle gap after each last beat.
module flow_framer
   import flow_pkg::framer_state_t;
#(
   parameter int unsigned DATAWIDTH = flow_pkg::DEFAULT_DATAWIDTH,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LEN_W     = 9,
   parameter int unsigned GAP       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATAWIDTH-1:0] s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic [LEN_W-1:0]     frame_len,
   output logic [DATAWIDTH-1:0] dout,
   output logic                 dout_tvalid,
   output logic                 dout_tlast,
   output logic                 overflow,
   output logic [15:0]          frame_cnt
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   logic [CW-1:0]        w_count;
   logic                 w_full;
   logic                 w_empty;
   logic [DATAWIDTH-1:0] w_head;
   logic                 w_rd_en;
   logic                 w_start;
   logic [LEN_W-1:0]     w_len_eff;

   framer_state_t        r_state;
   logic [LEN_W-1:0]     r_len;
   logic [LEN_W-1:0]     r_beat;
   logic [GW-1:0]        r_gap;
   logic [DATAWIDTH-1:0] r_dout;
   logic                 r_tvalid;
   logic                 r_tlast;
   logic                 r_overflow;
   logic [15:0]          r_frame_cnt;

   flow_fifo #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (s_tvalid),
      .i_wr_data (s_tdata),
      .i_rd_en   (w_rd_en),
      .o_rd_data (w_head),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign s_tready    = ~w_full;
   assign dout        = r_dout;
   assign dout_tvalid = r_tvalid;
   assign dout_tlast  = r_tlast;
   assign overflow    = r_overflow;
   assign frame_cnt   = r_frame_cnt;

   always_comb begin
      w_len_eff = frame_len;
      if (frame_len > LEN_W'(DEPTH)) begin
         w_len_eff = LEN_W'(DEPTH);
      end
   end

   // The !r_tvalid term keeps one idle cycle between frames even when GAP is 0.
   assign w_start = (r_state == flow_pkg::IDLE) && !r_tvalid && (w_len_eff != '0) &&
                    (LEN_W'(w_count) >= w_len_eff);
   assign w_rd_en = (w_start || (r_state == flow_pkg::BURST)) && !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= flow_pkg::IDLE;
         r_len       <= '0;
         r_beat      <= '0;
         r_gap       <= '0;
         r_dout      <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (s_tvalid && w_full) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            flow_pkg::IDLE: begin
               if (w_start) begin
                  r_len    <= w_len_eff;
                  r_beat   <= LEN_W'(1);
                  r_dout   <= w_head;
                  r_tvalid <= 1'b1;
                  r_tlast  <= (w_len_eff == LEN_W'(1));
                  r_gap    <= '0;
                  if (w_len_eff == LEN_W'(1)) begin
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                     r_state     <= (GAP == 0) ? flow_pkg::IDLE : flow_pkg::GAP;
                  end else begin
                     r_state <= flow_pkg::BURST;
                  end
               end else begin
                  r_dout   <= '0;
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
               end
            end
            flow_pkg::BURST: begin
               r_dout   <= w_head;
               r_tvalid <= 1'b1;
               r_beat   <= r_beat + LEN_W'(1);
               r_gap    <= '0;
               if ((r_beat + LEN_W'(1)) == r_len) begin
                  r_tlast     <= 1'b1;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_state     <= (GAP == 0) ? flow_pkg::IDLE : flow_pkg::GAP;
               end else begin
                  r_tlast <= 1'b0;
               end
            end
            flow_pkg::GAP: begin
               r_dout   <= '0;
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
               // First GAP cycle still shows the last beat, hence GAP+1 edges here.
               if (r_gap == GW'(GAP)) begin
                  r_state <= flow_pkg::IDLE;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: begin
               r_state  <= flow_pkg::IDLE;
               r_dout   <= '0;
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
            end
         endcase
      end
   end

endmodule
